// File: rtl/ga23_sdr_tile_server_if.sv
`default_nettype none
// ============================================================================
// ga23_sdr_tile_server_if : layer row-fetch bus and SDRAM read-port bundle
// Rev 1.0
// ============================================================================
interface ga23_sdr_tile_server_if #(
    parameter int NUM_LAYERS = 3,
    parameter int ADDR_W     = 22,
    parameter int MEM_ADDR_W = 25
);
    logic [NUM_LAYERS-1:0]        sdr_req;
    logic [NUM_LAYERS*ADDR_W-1:0] sdr_addr;
    logic [NUM_LAYERS*32-1:0]     sdr_data;
    logic [NUM_LAYERS-1:0]        sdr_rdy;
    logic [MEM_ADDR_W-1:0]        mem_addr;
    logic                         mem_req;
    logic                         mem_ack;
    logic [31:0]                  mem_data;
    logic                         mem_valid;
    logic [7:0]                   drop_count;

    modport slave (
        input  sdr_req, sdr_addr, mem_ack, mem_data, mem_valid,
        output sdr_data, sdr_rdy, mem_addr, mem_req, drop_count
    );

    modport master (
        output sdr_req, sdr_addr, mem_ack, mem_data, mem_valid,
        input  sdr_data, sdr_rdy, mem_addr, mem_req, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/ga23_sdr_tile_server.sv
`default_nettype none
// ============================================================================
// ga23_sdr_tile_server : round-robin tile-row fetch server onto one SDRAM read port
// Rev 1.0
// ============================================================================
module ga23_sdr_tile_server #(
    parameter int                    NUM_LAYERS = 3,
    parameter int                    ADDR_W     = 22,
    parameter int                    MEM_ADDR_W = 25,
    parameter logic [MEM_ADDR_W-1:0] ROM_BASE   = '0
) (
    input  wire                    clk,
    input  wire                    reset_n,
    ga23_sdr_tile_server_if.slave  bus
);
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_n;
    logic [NUM_LAYERS-1:0]      r_pending;
    logic [ADDR_W-1:0]          r_paddr [NUM_LAYERS];
    logic [IDX_W-1:0]           r_owner;
    logic [IDX_W-1:0]           r_rr_last;
    logic                       r_stale;
    logic [MEM_ADDR_W-1:0]      r_mem_addr;
    logic                       r_mem_req;
    logic [NUM_LAYERS*32-1:0]   r_sdr_data;
    logic [NUM_LAYERS-1:0]      r_sdr_rdy;
    logic [7:0]                 r_drop;

    logic                       w_grant_vld;
    logic [IDX_W-1:0]           w_grant_idx;
    logic                       w_do_grant;
    logic                       w_ack_take;
    logic                       w_deliver;
    logic [3:0]                 w_drop_inc;
    logic [8:0]                 w_drop_sum;

    // Cyclic search from rr_last+1; scanning downward lets the nearest hit win.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = NUM_LAYERS; k >= 1; k--) begin
            idx = (int'(r_rr_last) + k) % NUM_LAYERS;
            if (r_pending[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_n;
    end

    always_comb begin
        w_state_n  = r_state;
        w_do_grant = 1'b0;
        w_ack_take = 1'b0;
        w_deliver  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_do_grant = 1'b1;
                    w_state_n  = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_ack) begin
                    w_ack_take = 1'b1;
                    if (bus.mem_valid) begin
                        w_deliver = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_state_n = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.mem_valid) begin
                    w_deliver = 1'b1;
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // A re-request on the layer being granted this clk is not an overwrite.
    always_comb begin
        w_drop_inc = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (bus.sdr_req[i] && r_pending[i] &&
                !(w_do_grant && (w_grant_idx == IDX_W'(i))))
                w_drop_inc = w_drop_inc + 4'd1;
        end
        if (w_deliver && r_stale)
            w_drop_inc = w_drop_inc + 4'd1;
        w_drop_sum = {1'b0, r_drop} + 9'(w_drop_inc);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pending  <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) r_paddr[i] <= '0;
            r_owner    <= '0;
            r_rr_last  <= IDX_W'(NUM_LAYERS - 1);
            r_stale    <= 1'b0;
            r_mem_addr <= '0;
            r_mem_req  <= 1'b0;
            r_sdr_data <= '0;
            r_sdr_rdy  <= '0;
            r_drop     <= '0;
        end else begin
            r_sdr_rdy <= '0;
            r_drop    <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (bus.sdr_req[i]) begin
                    r_pending[i] <= 1'b1;
                    r_paddr[i]   <= bus.sdr_addr[i*ADDR_W +: ADDR_W];
                end else if (w_do_grant && (w_grant_idx == IDX_W'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end

            if (w_do_grant) begin
                r_owner    <= w_grant_idx;
                r_rr_last  <= w_grant_idx;
                r_stale    <= bus.sdr_req[w_grant_idx];
                r_mem_addr <= ROM_BASE + MEM_ADDR_W'(r_paddr[w_grant_idx]);
                r_mem_req  <= 1'b1;
            end else if (r_state != S_IDLE && bus.sdr_req[r_owner]) begin
                r_stale <= 1'b1;
            end

            if (w_ack_take)
                r_mem_req <= 1'b0;

            if (w_deliver && !r_stale) begin
                r_sdr_data[32*r_owner +: 32] <= bus.mem_data;
                r_sdr_rdy[r_owner]           <= 1'b1;
            end
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_req    = r_mem_req;
    assign bus.sdr_data   = r_sdr_data;
    assign bus.sdr_rdy    = r_sdr_rdy;
    assign bus.drop_count = r_drop;
endmodule
`default_nettype wire

// File: tb/tb_ga23_sdr_tile_server.sv
`default_nettype none
// ============================================================================
// tb_ga23_sdr_tile_server : directed checks of fetch arbitration and delivery
// Rev 1.0
// ============================================================================
module tb_ga23_sdr_tile_server;
    localparam int NL = 3;
    localparam int AW = 22;
    localparam int MW = 25;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    ga23_sdr_tile_server_if #(.NUM_LAYERS(NL), .ADDR_W(AW), .MEM_ADDR_W(MW)) bus ();

    ga23_sdr_tile_server #(
        .NUM_LAYERS (NL),
        .ADDR_W     (AW),
        .MEM_ADDR_W (MW),
        .ROM_BASE   (25'h100000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [2:0] m, input logic [21:0] a0,
                         input logic [21:0] a1, input logic [21:0] a2);
        if (m[0]) bus.sdr_addr[0*AW +: AW] = a0;
        if (m[1]) bus.sdr_addr[1*AW +: AW] = a1;
        if (m[2]) bus.sdr_addr[2*AW +: AW] = a2;
        bus.sdr_req = m;
        @(negedge clk);
        bus.sdr_req = '0;
    endtask

    task automatic wait_req(input logic [24:0] exp_addr);
        int n;
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mem_req_seen", 128'(bus.mem_req), 128'(1'b1));
        chk("mem_addr", 128'(bus.mem_addr), 128'(exp_addr));
    endtask

    task automatic ack_only();
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("mem_req_drop", 128'(bus.mem_req), 128'(1'b0));
    endtask

    task automatic valid_only(input logic [31:0] d);
        bus.mem_valid = 1'b1;
        bus.mem_data  = d;
        @(negedge clk);
        bus.mem_valid = 1'b0;
    endtask

    task automatic chk_rdy(input logic [2:0] mask, input int lay, input logic [31:0] d);
        chk("sdr_rdy", 128'(bus.sdr_rdy), 128'(mask));
        chk("sdr_data", 128'(bus.sdr_data[lay*32 +: 32]), 128'(d));
        @(negedge clk);
        chk("sdr_rdy_pulse", 128'(bus.sdr_rdy), 128'(3'b000));
    endtask

    task automatic serve(input logic [24:0] a, input logic [31:0] d, input int delay,
                         input bit same, input logic [2:0] mask, input int lay);
        wait_req(a);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("hold_req", 128'(bus.mem_req), 128'(1'b1));
            chk("hold_addr", 128'(bus.mem_addr), 128'(a));
        end
        if (same) begin
            bus.mem_ack   = 1'b1;
            bus.mem_valid = 1'b1;
            bus.mem_data  = d;
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_valid = 1'b0;
        end else begin
            ack_only();
            valid_only(d);
        end
        chk_rdy(mask, lay, d);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n       = 1'b0;
        bus.sdr_req   = '0;
        bus.sdr_addr  = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_data  = '0;
        bus.mem_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 128'(bus.mem_req), 128'(1'b0));
        chk("rst_mem_addr", 128'(bus.mem_addr), 128'(25'h0));
        chk("rst_sdr_rdy", 128'(bus.sdr_rdy), 128'(3'b000));
        chk("rst_sdr_data", 128'(bus.sdr_data), 128'(96'h0));
        chk("rst_drop", 128'(bus.drop_count), 128'(8'h00));
        reset_n = 1'b1;
        @(negedge clk);

        // Single fetch, with earliest-request latency
        pulse(3'b001, 22'h001234, 22'h0, 22'h0);
        chk("latency_req_low", 128'(bus.mem_req), 128'(1'b0));
        @(negedge clk);
        chk("latency_req_high", 128'(bus.mem_req), 128'(1'b1));
        serve(25'h101234, 32'hDEADBEEF, 3, 1'b0, 3'b001, 0);

        // Round robin from reset
        do_reset();
        pulse(3'b111, 22'h000010, 22'h000020, 22'h000030);
        serve(25'h100010, 32'h0A0A0001, 0, 1'b1, 3'b001, 0);
        serve(25'h100020, 32'h0B0B0001, 0, 1'b1, 3'b010, 1);
        serve(25'h100030, 32'h0C0C0001, 0, 1'b1, 3'b100, 2);
        pulse(3'b101, 22'h000014, 22'h0, 22'h000034);
        serve(25'h100014, 32'h0A0A0002, 0, 1'b1, 3'b001, 0);
        serve(25'h100034, 32'h0C0C0002, 0, 1'b1, 3'b100, 2);
        pulse(3'b011, 22'h000018, 22'h000028, 22'h0);
        serve(25'h100018, 32'h0A0A0003, 0, 1'b1, 3'b001, 0);
        serve(25'h100028, 32'h0B0B0002, 0, 1'b1, 3'b010, 1);
        chk("rr_data0", 128'(bus.sdr_data[31:0]), 128'(32'h0A0A0003));

        // Overwrite of a pending, not-yet-granted layer
        pulse(3'b001, 22'h000040, 22'h0, 22'h0);
        wait_req(25'h100040);
        pulse(3'b010, 22'h0, 22'h000050, 22'h0);
        pulse(3'b010, 22'h0, 22'h000054, 22'h0);
        chk("ovr_drop", 128'(bus.drop_count), 128'(8'd1));
        serve(25'h100040, 32'h11111111, 0, 1'b0, 3'b001, 0);
        serve(25'h100054, 32'h22222222, 0, 1'b0, 3'b010, 1);
        chk("ovr_drop_after", 128'(bus.drop_count), 128'(8'd1));

        // Stale: re-request of the owner while waiting for data
        pulse(3'b100, 22'h0, 22'h0, 22'h000060);
        wait_req(25'h100060);
        ack_only();
        pulse(3'b100, 22'h0, 22'h0, 22'h000064);
        valid_only(32'h33333333);
        chk_rdy(3'b000, 2, 32'h0C0C0002);
        chk("stale_drop", 128'(bus.drop_count), 128'(8'd2));
        serve(25'h100064, 32'h44444444, 0, 1'b0, 3'b100, 2);

        // Backpressure, then ack+valid together
        pulse(3'b010, 22'h0, 22'h3FFFFC, 22'h0);
        serve(25'h4FFFFC, 32'h55555555, 10, 1'b0, 3'b010, 1);
        pulse(3'b001, 22'h000070, 22'h0, 22'h0);
        serve(25'h100070, 32'h66666666, 2, 1'b1, 3'b001, 0);

        // Reset during WAIT, late mem_valid ignored
        pulse(3'b001, 22'h000080, 22'h0, 22'h0);
        wait_req(25'h100080);
        ack_only();
        pulse(3'b010, 22'h0, 22'h000090, 22'h0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n       = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_data  = 32'h77777777;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        chk("mrst_rdy", 128'(bus.sdr_rdy), 128'(3'b000));
        chk("mrst_req", 128'(bus.mem_req), 128'(1'b0));
        chk("mrst_addr", 128'(bus.mem_addr), 128'(25'h0));
        chk("mrst_data", 128'(bus.sdr_data), 128'(96'h0));
        chk("mrst_drop", 128'(bus.drop_count), 128'(8'h00));
        repeat (4) @(negedge clk);
        chk("mrst_pending_clear", 128'(bus.mem_req), 128'(1'b0));

        // Double drops per clk and saturation
        pulse(3'b001, 22'h0000A0, 22'h0, 22'h0);
        wait_req(25'h1000A0);
        bus.sdr_addr[1*AW +: AW] = 22'h0000B0;
        bus.sdr_addr[2*AW +: AW] = 22'h0000C0;
        bus.sdr_req = 3'b110;
        repeat (3) @(negedge clk);
        chk("drop_double", 128'(bus.drop_count), 128'(8'd4));
        repeat (130) @(negedge clk);
        bus.sdr_req = '0;
        chk("drop_sat", 128'(bus.drop_count), 128'(8'hFF));
        chk("sat_req_hold", 128'(bus.mem_req), 128'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
